rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
//
// PURPOSE
// Round-robin arbiter that drives the select input of an N:1 mux built from mux2 stages.
// Up to N requesters compete for the shared mux output; one owner is granted at a time.
// The grant is held until the owner signals done, drops its request, or hits a hold timeout.
// The binary select feeds the mux tree directly; the one-hot grant goes back to the requesters.
//
// PARAMETERS
// N         4    number of requesters, 2..16
// SEL_W     $clog2(N)  select width, derived; do not override
// MAX_HOLD  8    max cycles one owner may hold the grant, 1..255; forced release at the limit
//
// PORTS
// clk      in   1      rising-edge clock
// rst_n    in   1      asynchronous active-low reset
// req      in   N      request per requester; bit i = requester i
// done     in   1      current owner finished; sampled only while active=1
// sel      out  SEL_W  binary index of owner, to the mux select tree
// grant    out  N      one-hot owner; all zero when idle
// active   out  1      a grant is in force
// timeout  out  1      one-cycle pulse when a grant is force-released by MAX_HOLD
//
// BEHAVIOUR
// - Reset (rst_n=0, async): sel=0, grant=0, active=0, timeout=0, priority pointer ptr=0,
//   hold counter=0, state=IDLE. Outputs go to these values immediately, not at the next edge.
// - All outputs are registered. No combinational path from req or done to any output.
// - States: IDLE (no owner), OWN (owner = sel).
// - IDLE: if req!=0 at an edge, pick the first set bit scanning ptr, ptr+1, ... mod N.
//   The owner is granted at that edge: grant/sel/active are valid the cycle after req is seen.
//   Latency is 1 cycle. If req==0, stay in IDLE.
// - OWN: the hold counter starts at 1 on the grant cycle and increments each cycle.
//   Release happens at an edge where any of these is true:
//   done=1, req[sel]=0, or counter==MAX_HOLD.
// - On release: ptr <= (sel+1) mod N, so the releasing owner gets lowest priority next round.
//   If any req bit other than the releasing owner is set, the new owner is chosen with the
//   updated ptr and granted at the same edge (back-to-back, no idle bubble).
//   Otherwise go to IDLE: grant=0, active=0. sel keeps its last value.
// - The releasing owner is excluded from the same-edge re-arbitration. It may win again
//   from IDLE the next cycle if it is the only requester.
// - timeout=1 for exactly the cycle after a release caused only by counter==MAX_HOLD.
//   If done=1 or req[sel]=0 at that same edge, the release is normal and timeout stays 0.
// - done while in IDLE is ignored. req bits for indices >= N do not exist.
// - MAX_HOLD=1: every grant lasts exactly one cycle, which gives pure per-cycle rotation.
// - ptr wraps from N-1 to 0. For N not a power of 2, sel never exceeds N-1.
// - When a reset asserts mid-grant, the grant is dropped at once. After release, arbitration
//   restarts from ptr=0 on the first edge with rst_n=1.
// - Invariants, checked by assertions:
//   grant == (active ? 1<<sel : 0); grant has at most one bit set; timeout implies !active or a new sel.
//
// TESTING
// T1 reset: rst_n=0 while req=4'b1111 -> sel=0, grant=0, active=0; release, 1 edge -> grant=4'b0001, sel=0.
// T2 rotation: req=4'b1111 held, done pulsed each grant cycle -> sel sequence 0,1,2,3,0, no idle cycles.
// T3 skip/wrap: ptr=3, req=4'b0101 -> grant=4'b0001 (sel=0); after done -> grant=4'b0100 (sel=2).
// T4 timeout: MAX_HOLD=8, req=4'b0011, done=0 -> owner 0 holds 8 cycles, then grant=4'b0010 and timeout=1 for 1 cycle.
// T5 drop: owner 2 granted, req[2] falls with req=4'b0000 -> next cycle active=0, grant=0, timeout=0; done in IDLE has no effect.
// T6 mid-op reset plus checker: reset during a grant to sel=3 -> outputs cleared asynchronously;
//    random req/done for 1000 cycles against a behavioural model -> 0 mismatches via === checks.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of an N:1 mux tree. One owner at a time;
// the grant is held until done, request drop, or MAX_HOLD cycles, then rotates.
module rr_mux_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     grant,
  output logic             active,
  output logic             timeout
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_d;
  logic [N-1:0]     grant_d;
  logic             active_d, timeout_d;

  logic [SEL_W-1:0] ptr_after_release;
  logic [SEL_W:0]   pick_idle, pick_release;
  logic             rel_done, rel_drop, rel_hold;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod N.
  function automatic logic [SEL_W:0] pick_first(input logic [N-1:0] r,
                                                 input logic [SEL_W-1:0] start);
    logic             found;
    logic [SEL_W-1:0] idx;
    int               j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && r[j]) begin
        found = 1'b1;
        idx   = SEL_W'(j);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N-1:0] o;
    o      = '0;
    o[idx] = 1'b1;
    return o;
  endfunction

  assign ptr_after_release = (sel == SEL_W'(N - 1)) ? '0 : sel + SEL_W'(1);
  assign pick_idle         = pick_first(req, ptr_q);
  // The releasing owner is masked out so it cannot re-win at the same edge.
  assign pick_release      = pick_first(req & ~grant, ptr_after_release);

  assign rel_done = done;
  assign rel_drop = !req[sel];
  assign rel_hold = (cnt_q == 8'(MAX_HOLD));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
  // which is what keeps synthesis from inferring latches.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    sel_d     = sel;
    grant_d   = grant;
    active_d  = active;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_idle[SEL_W]) begin
          state_d  = OWN;
          sel_d    = pick_idle[SEL_W-1:0];
          grant_d  = onehot(pick_idle[SEL_W-1:0]);
          active_d = 1'b1;
          cnt_d    = 8'd1;
        end
      end
      OWN: begin
        if (rel_done || rel_drop || rel_hold) begin
          ptr_d     = ptr_after_release;
          timeout_d = rel_hold && !rel_done && !rel_drop;
          if (pick_release[SEL_W]) begin
            sel_d   = pick_release[SEL_W-1:0];
            grant_d = onehot(pick_release[SEL_W-1:0]);
            cnt_d   = 8'd1;
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            active_d = 1'b0;
            cnt_d    = 8'd0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel     <= '0;
      grant   <= '0;
      active  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel     <= sel_d;
      grant   <= grant_d;
      active  <= active_d;
      timeout <= timeout_d;
    end
  end

  a_grant_matches_sel: assert property (@(posedge clk) disable iff (!rst_n)
    grant == (active ? onehot(sel) : '0));
  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant));
  a_timeout_moves: assert property (@(posedge clk) disable iff (!rst_n)
    timeout |-> (!active || sel != $past(sel)));

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter (N=4, MAX_HOLD=8): directed scenarios plus a
// randomized run against a behavioural round-robin model.
module tb_rr_mux_arbiter;
  localparam int N = 4;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       active;
  logic       timeout;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state: owner index (-1 = nobody), rotation pointer, hold count.
  int   m_owner, m_ptr, m_cnt, m_sel;
  bit   m_timeout;

  rr_mux_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .sel(sel), .grant(grant), .active(active), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] observed();
    return {sel, grant, active, timeout};
  endfunction

  function automatic logic [7:0] packed_exp(int s, logic [3:0] g, bit a, bit t);
    return {2'(s), g, a, t};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0; m_timeout = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input bit d);
    int old;
    m_timeout = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (r[j]) begin m_owner = j; m_sel = j; m_cnt = 1; break; end
      end
    end else if (d || !r[m_owner] || m_cnt == MAX_HOLD) begin
      m_timeout = !d && r[m_owner];
      old = m_owner;
      m_ptr = (old + 1) % N;
      m_owner = -1;
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (j != old && r[j]) begin m_owner = j; m_sel = j; m_cnt = 1; break; end
      end
    end else begin
      m_cnt++;
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {2'(m_sel), g, m_owner >= 0, m_timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; done = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; done = 1'b0;
    #3;
    vectors++;
    if (observed() !== packed_exp(0, 4'b0000, 0, 0)) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", observed(), packed_exp(0, 4'b0000, 0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (observed() !== packed_exp(0, 4'b0001, 1, 0)) begin
      miscompares++;
      $display("FAIL reset_first_grant: got %b want %b", observed(), packed_exp(0, 4'b0001, 1, 0));
    end
  endtask

  task automatic test_rotation();
    int exp_sel [4] = '{1, 2, 3, 0};
    logic [3:0] g;
    do_reset();
    req = 4'b1111;
    tick();
    done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      g = '0; g[exp_sel[i]] = 1'b1;
      vectors++;
      if (observed() !== packed_exp(exp_sel[i], g, 1, 0)) begin
        miscompares++;
        $display("FAIL rotation_%0d: got %b want %b", i, observed(), packed_exp(exp_sel[i], g, 1, 0));
      end
    end
    done = 1'b0;
  endtask

  task automatic test_skip_wrap();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0101; done = 1'b1;
    tick();
    vectors++;
    if (observed() !== packed_exp(0, 4'b0001, 1, 0)) begin
      miscompares++;
      $display("FAIL skip_wrap_to0: got %b want %b", observed(), packed_exp(0, 4'b0001, 1, 0));
    end
    tick();
    vectors++;
    if (observed() !== packed_exp(2, 4'b0100, 1, 0)) begin
      miscompares++;
      $display("FAIL skip_wrap_to2: got %b want %b", observed(), packed_exp(2, 4'b0100, 1, 0));
    end
    done = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0011;
    tick();
    for (int i = 1; i <= MAX_HOLD; i++) begin
      vectors++;
      if (observed() !== packed_exp(0, 4'b0001, 1, 0)) begin
        miscompares++;
        $display("FAIL timeout_hold_%0d: got %b want %b", i, observed(), packed_exp(0, 4'b0001, 1, 0));
      end
      if (i < MAX_HOLD) tick();
    end
    tick();
    vectors++;
    if (observed() !== packed_exp(1, 4'b0010, 1, 1)) begin
      miscompares++;
      $display("FAIL timeout_release: got %b want %b", observed(), packed_exp(1, 4'b0010, 1, 1));
    end
    tick();
    vectors++;
    if (observed() !== packed_exp(1, 4'b0010, 1, 0)) begin
      miscompares++;
      $display("FAIL timeout_pulse_end: got %b want %b", observed(), packed_exp(1, 4'b0010, 1, 0));
    end
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    vectors++;
    if (observed() !== packed_exp(2, 4'b0000, 0, 0)) begin
      miscompares++;
      $display("FAIL drop_to_idle: got %b want %b", observed(), packed_exp(2, 4'b0000, 0, 0));
    end
    done = 1'b1;
    tick();
    vectors++;
    if (observed() !== packed_exp(2, 4'b0000, 0, 0)) begin
      miscompares++;
      $display("FAIL done_in_idle: got %b want %b", observed(), packed_exp(2, 4'b0000, 0, 0));
    end
    done = 1'b0;
  endtask

  task automatic test_midop_reset();
    do_reset();
    req = 4'b1000;
    tick();
    vectors++;
    if (observed() !== packed_exp(3, 4'b1000, 1, 0)) begin
      miscompares++;
      $display("FAIL midop_grant3: got %b want %b", observed(), packed_exp(3, 4'b1000, 1, 0));
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (observed() !== packed_exp(0, 4'b0000, 0, 0)) begin
      miscompares++;
      $display("FAIL midop_async_clear: got %b want %b", observed(), packed_exp(0, 4'b0000, 0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1010;
    tick();
    vectors++;
    if (observed() !== packed_exp(1, 4'b0010, 1, 0)) begin
      miscompares++;
      $display("FAIL midop_restart_ptr0: got %b want %b", observed(), packed_exp(1, 4'b0010, 1, 0));
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      done = ($urandom_range(0, 5) == 0);
      @(posedge clk);
      model_edge(req, done);
      #1;
      exp = model_out();
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("FAIL random_cycle_%0d: got %b want %b (req=%b done=%b)", c, observed(), exp, req, done);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_skip_wrap();
    test_timeout();
    test_drop();
    test_midop_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
